store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries (power of two, ≥2).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 st_valid  in  1  core presents a store this cycle.
REQ-005 st_addr  in  32  store word address, same indexing as the data memory addr port.
REQ-006 st_data  in  32  store data, low-aligned (byte0 = bits 7:0).
REQ-007 st_wen  in  4  store byte enables; legal values 0000, 0001, 0011, 1111.
REQ-008 st_ready  out  1  buffer accepts a store this cycle.
REQ-009 ld_en  in  1  core performs a load this cycle.
REQ-010 ld_addr  in  32  load word address.
REQ-011 mem_rdata  in  32  asynchronous read data from the data memory at ld_addr.
REQ-012 ld_data  out  32  load result after forwarding.
REQ-013 ld_stall  out  1  load cannot complete this cycle; core holds.
REQ-014 mem_addr / mem_wdata / mem_wen  out  32/32/4  write port to the data memory.
REQ-015 drain_hold  in  1  suspend draining this cycle.
REQ-016 empty  out  1  no entries pending.
REQ-017 count  out  $clog2(DEPTH)+1  occupied entries.
REQ-018 wen_err  out  1  one-cycle pulse on an illegal st_wen.

Function
REQ-019 FIFO ordering: stores drain to memory in acceptance order.
REQ-020 st_ready = (count != DEPTH); a store arriving while full is not accepted, even if a drain occurs the same edge.
REQ-021 Enqueue on edge when st_valid & st_ready & st_wen legal & st_wen != 0000.
REQ-022 st_wen == 0000 with st_valid: no enqueue, no error.
REQ-023 Illegal st_wen with st_valid & st_ready: no enqueue; wen_err high for the following cycle.
REQ-024 Drain: when !empty & !drain_hold, mem_addr/mem_wdata/mem_wen present the head entry combinationally; the head pops on that edge.
REQ-025 When empty or drain_hold: mem_wen = 0000; mem_addr/mem_wdata hold the head values (zero when empty).
REQ-026 Latency: store accepted at edge N is written to memory no earlier than edge N+1.
REQ-027 Simultaneous enqueue and drain: count unchanged; both occur.
REQ-028 Pointers wrap modulo DEPTH; count distinguishes full from empty.
REQ-029 Forwarding search covers all valid entries including the head being drained this cycle; the incoming same-cycle store is excluded.
REQ-030 No match on ld_addr (32-bit compare): ld_data = mem_rdata, ld_stall = 0.
REQ-031 Youngest match has st_wen 1111: ld_data = that entry's data, ld_stall = 0.
REQ-032 Youngest match has a partial st_wen: ld_stall = 1 until no partial match remains; draining continues regardless of drain_hold while ld_stall = 1.
REQ-033 ld_en = 0: ld_stall = 0, ld_data = mem_rdata.

Reset
REQ-034 rst clears pointers and count, invalidates all entries, and discards pending stores mid-drain.
REQ-035 During/after reset: st_ready = 1, empty = 1, count = 0, mem_wen = 0000, mem_addr = mem_wdata = 0, ld_stall = 0, wen_err = 0.
REQ-036 Entry data storage requires no reset; valid bits do.

Structure
REQ-037 Shared package sb_pkg: entry struct {addr[31:0], data[31:0], wen[3:0]}, constants WEN_NONE=0000, WEN_B=0001, WEN_H=0011, WEN_W=1111, and a legal-wen function.
REQ-038 One sub-module sb_fwd_match: combinational youngest-first address match returning hit, full-word flag, and data.

Verification
REQ-039 Store addr 0x10, data 0xDEADBEEF, wen 1111 at edge 1 -> mem_wen = 1111 with addr 0x10 during cycle 2; empty = 1 after edge 2.
REQ-040 drain_hold = 1, five stores 0x1..0x5 -> st_ready = 0 after four; release -> memory writes in order 0x1..0x4, fifth accepted once count < 4.
REQ-041 Stores to 0x20 with data 0x11111111 then 0x22222222 (both 1111) held; load 0x20 -> ld_data = 0x22222222, ld_stall = 0.
REQ-042 Store 0x30 wen 0001 held; load 0x30 -> ld_stall = 1 until the entry drains despite drain_hold, then ld_data = mem_rdata.
REQ-043 st_wen = 0111 -> not enqueued, wen_err pulses one cycle, count unchanged.
REQ-044 Three entries pending, assert rst mid-drain -> count = 0, mem_wen = 0000 immediately, no further writes after release.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared store-buffer types: entry layout, byte-enable encodings, legality check.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package sb_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  wen;
   } sb_entry_t;

   localparam logic [3:0] WEN_NONE = 4'b0000;
   localparam logic [3:0] WEN_B    = 4'b0001;
   localparam logic [3:0] WEN_H    = 4'b0011;
   localparam logic [3:0] WEN_W    = 4'b1111;

   // Only low-aligned byte, half and word enables exist on the core side.
   function automatic logic wen_legal(input logic [3:0] wen);
      return (wen == WEN_NONE) || (wen == WEN_B) || (wen == WEN_H) || (wen == WEN_W);
   endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-first address match over the buffered stores for load forwarding.
// Latency: purely combinational.
// Backpressure: none; the caller turns a partial hit into a load stall.
module sb_fwd_match
   import sb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
)
(
   input  sb_entry_t [DEPTH-1:0] ent,
   input  logic [DEPTH-1:0]      vld,
   input  logic [AW-1:0]         head,
   input  logic [31:0]           addr,
   output logic                  hit,
   output logic                  full,
   output logic [31:0]           data
);

   // Walk oldest to youngest so the last matching entry seen is the youngest.
   always_comb begin
      logic [AW-1:0] idx;
      idx  = '0;
      hit  = 1'b0;
      full = 1'b0;
      data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + AW'(k);
         if (vld[idx] && (ent[idx].addr == addr)) begin
            hit  = 1'b1;
            full = (ent[idx].wen == WEN_W);
            data = ent[idx].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between core and data memory, with load forwarding.
// Latency: a store accepted on one edge drains to memory on the next edge at the earliest.
// Backpressure: st_ready drops when full; partial-overlap loads stall and force draining.
module store_buffer
   import sb_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   st_valid,
   input  logic [31:0]            st_addr,
   input  logic [31:0]            st_data,
   input  logic [3:0]             st_wen,
   output logic                   st_ready,
   input  logic                   ld_en,
   input  logic [31:0]            ld_addr,
   input  logic [31:0]            mem_rdata,
   output logic [31:0]            ld_data,
   output logic                   ld_stall,
   output logic [31:0]            mem_addr,
   output logic [31:0]            mem_wdata,
   output logic [3:0]             mem_wen,
   input  logic                   drain_hold,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   wen_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   sb_entry_t [DEPTH-1:0] ent;
   sb_entry_t             head_ent;
   logic [DEPTH-1:0]      vld;
   logic [AW-1:0]         head;
   logic [AW-1:0]         tail;
   logic [AW:0]           cnt;
   logic                  wen_ok;
   logic                  enq;
   logic                  deq;
   logic                  fwd_hit;
   logic                  fwd_full;
   logic [31:0]           fwd_data;

   // A full buffer refuses stores even when the head drains on the same edge.
   assign wen_ok   = wen_legal(st_wen);
   assign st_ready = (cnt != FULL_CNT);
   assign enq      = st_valid & st_ready & wen_ok & (st_wen != WEN_NONE);
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign head_ent = ent[head];

   sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
      .ent  (ent),
      .vld  (vld),
      .head (head),
      .addr (ld_addr),
      .hit  (fwd_hit),
      .full (fwd_full),
      .data (fwd_data)
   );

   // A partial overlap cannot be merged here, so the load waits and draining is forced.
   assign ld_stall = ld_en & fwd_hit & ~fwd_full;
   assign ld_data  = (ld_en & fwd_hit & fwd_full) ? fwd_data : mem_rdata;
   assign deq      = ~empty & (~drain_hold | ld_stall);

   // Write port shows the head whenever one exists, but only strobes when popping.
   assign mem_addr  = empty ? '0 : head_ent.addr;
   assign mem_wdata = empty ? '0 : head_ent.data;
   assign mem_wen   = deq ? head_ent.wen : WEN_NONE;

   // Pointers, occupancy, valid bits and the illegal-enable pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         cnt     <= '0;
         vld     <= '0;
         wen_err <= 1'b0;
      end else begin
         if (enq) begin
            tail      <= tail + AW'(1);
            vld[tail] <= 1'b1;
         end
         if (deq) begin
            head      <= head + AW'(1);
            vld[head] <= 1'b0;
         end
         cnt     <= cnt + (AW+1)'(enq) - (AW+1)'(deq);
         wen_err <= st_valid & st_ready & ~wen_ok;
      end
   end

   // Entry payload; valid bits gate every use, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (enq) begin
         ent[tail] <= '{addr: st_addr, data: st_data, wen: st_wen};
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scenario tasks plus a write-order scoreboard.
// Memory is modelled in the bench; observed writes are captured on the falling edge.
// Expected writes are queued as stores are issued and compared in order at the end.
module tb_store_buffer;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [3:0]  st_wen;
   logic        st_ready;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] mem_rdata;
   logic [31:0] ld_data;
   logic        ld_stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wen;
   logic        drain_hold;
   logic        empty;
   logic [2:0]  count;
   logic        wen_err;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  w;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         obs_q[$];
   logic [31:0] mem_model [0:255];
   int          n_checks = 0;
   int          n_fail   = 0;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .st_valid   (st_valid),
      .st_addr    (st_addr),
      .st_data    (st_data),
      .st_wen     (st_wen),
      .st_ready   (st_ready),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .mem_rdata  (mem_rdata),
      .ld_data    (ld_data),
      .ld_stall   (ld_stall),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wen    (mem_wen),
      .drain_hold (drain_hold),
      .empty      (empty),
      .count      (count),
      .wen_err    (wen_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem_model[ld_addr[7:0]];

   // Capture each strobed write mid-cycle and apply it to the memory model.
   initial begin
      for (int i = 0; i < 256; i++) mem_model[i] = 32'hC0DE_0000 + i;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && mem_wen !== 4'b0000) begin
            obs_q.push_back('{mem_addr, mem_wdata, mem_wen});
            for (int b = 0; b < 4; b++)
               if (mem_wen[b]) mem_model[mem_addr[7:0]][8*b +: 8] = mem_wdata[8*b +: 8];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one legal store for a single cycle, assuming the bench knows there is room.
   task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      st_valid = 1'b1; st_addr = a; st_data = d; st_wen = w;
      tick();
      st_valid = 1'b0;
      exp_q.push_back('{a, d, w});
   endtask

   task automatic wait_empty(input string name);
      for (int i = 0; i < 20 && empty !== 1'b1; i++) tick();
      n_checks++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL %s drain timeout: empty=%b required 1", name, empty); end
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", st_ready); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", empty); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
      n_checks++; if (mem_wen !== 4'b0000) begin n_fail++; $display("FAIL rst_mem_wen got %b want 0000", mem_wen); end
      n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
      n_checks++; if (ld_stall !== 1'b0 || wen_err !== 1'b0) begin n_fail++; $display("FAIL rst_flags stall=%b err=%b want 0/0", ld_stall, wen_err); end
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_checks++; if (empty !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL rst_release empty=%b count=%0d want 1/0", empty, count); end
   endtask

   task automatic test_single();
      drain_hold = 1'b0;
      put(32'h10, 32'hDEADBEEF, 4'b1111);
      #1;
      n_checks++; if (mem_wen !== 4'b1111) begin n_fail++; $display("FAIL single_wen got %b want 1111", mem_wen); end
      n_checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_bus got %h/%h want 10/deadbeef", mem_addr, mem_wdata); end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
      tick();
      n_checks++; if (empty !== 1'b1 || mem_wen !== 4'b0000) begin n_fail++; $display("FAIL single_after empty=%b wen=%b want 1/0000", empty, mem_wen); end
   endtask

   task automatic test_back_to_back();
      drain_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         st_valid = 1'b1; st_addr = 32'h40 + i; st_data = 32'hB0 + i; st_wen = 4'b1111;
         tick();
         exp_q.push_back('{32'h40 + i, 32'hB0 + i, 4'b1111});
         n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d want 1", i, count); end
      end
      st_valid = 1'b0;
      wait_empty("b2b");
   endtask

   task automatic test_full_order();
      drain_hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready[%0d] got %b want 1", i, st_ready); end
         put(i, 32'h1000_0000 + i, 4'b1111);
      end
      n_checks++; if (st_ready !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL full_state ready=%b count=%0d want 0/4", st_ready, count); end
      st_valid = 1'b1; st_addr = 32'h5; st_data = 32'h1000_0005; st_wen = 4'b1111;
      tick();
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_refuse count got %0d want 4", count); end
      drain_hold = 1'b0;
      #1;
      n_checks++; if (st_ready !== 1'b0 || mem_wen !== 4'b1111 || mem_addr !== 32'h1) begin n_fail++; $display("FAIL full_release ready=%b wen=%b addr=%h want 0/1111/1", st_ready, mem_wen, mem_addr); end
      tick();
      n_checks++; if (count !== 3'd3 || st_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop count=%0d ready=%b want 3/1", count, st_ready); end
      tick();
      exp_q.push_back('{32'h5, 32'h1000_0005, 4'b1111});
      st_valid = 1'b0;
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_enq_deq count got %0d want 3", count); end
      wait_empty("full");
   endtask

   task automatic test_fwd_full();
      drain_hold = 1'b1;
      put(32'h20, 32'h11111111, 4'b1111);
      put(32'h20, 32'h22222222, 4'b1111);
      ld_en = 1'b1; ld_addr = 32'h20;
      #1;
      n_checks++; if (ld_data !== 32'h22222222 || ld_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_youngest data=%h stall=%b want 22222222/0", ld_data, ld_stall); end
      ld_addr = 32'h24;
      #1;
      n_checks++; if (ld_data !== 32'hC0DE0024 || ld_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_miss data=%h stall=%b want c0de0024/0", ld_data, ld_stall); end
      st_valid = 1'b1; st_addr = 32'h28; st_data = 32'h33333333; st_wen = 4'b1111; ld_addr = 32'h28;
      #1;
      n_checks++; if (ld_data !== 32'hC0DE0028) begin n_fail++; $display("FAIL fwd_same_cycle data=%h want c0de0028", ld_data); end
      tick();
      st_valid = 1'b0;
      exp_q.push_back('{32'h28, 32'h33333333, 4'b1111});
      n_checks++; if (ld_data !== 32'h33333333) begin n_fail++; $display("FAIL fwd_next_cycle data=%h want 33333333", ld_data); end
      ld_en = 1'b0;
      #1;
      n_checks++; if (ld_data !== 32'hC0DE0028 || ld_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_ld_off data=%h stall=%b want c0de0028/0", ld_data, ld_stall); end
      drain_hold = 1'b0;
      wait_empty("fwd");
   endtask

   task automatic test_partial();
      drain_hold = 1'b1;
      put(32'h34, 32'h44444444, 4'b1111);
      put(32'h30, 32'h000000AB, 4'b0001);
      ld_en = 1'b1; ld_addr = 32'h30;
      #1;
      n_checks++; if (ld_stall !== 1'b1 || mem_wen !== 4'b1111 || mem_addr !== 32'h34) begin n_fail++; $display("FAIL part_first stall=%b wen=%b addr=%h want 1/1111/34", ld_stall, mem_wen, mem_addr); end
      tick();
      n_checks++; if (ld_stall !== 1'b1 || mem_wen !== 4'b0001 || mem_addr !== 32'h30) begin n_fail++; $display("FAIL part_second stall=%b wen=%b addr=%h want 1/0001/30", ld_stall, mem_wen, mem_addr); end
      tick();
      n_checks++; if (ld_stall !== 1'b0 || ld_data !== 32'hC0DE00AB || count !== 3'd0) begin n_fail++; $display("FAIL part_done stall=%b data=%h count=%0d want 0/c0de00ab/0", ld_stall, ld_data, count); end
      ld_en = 1'b0;
      drain_hold = 1'b0;
   endtask

   task automatic test_wen_err();
      drain_hold = 1'b1;
      put(32'h50, 32'h55, 4'b1111);
      st_valid = 1'b1; st_addr = 32'h54; st_data = 32'h77; st_wen = 4'b0111;
      tick();
      st_valid = 1'b0;
      n_checks++; if (wen_err !== 1'b1 || count !== 3'd1) begin n_fail++; $display("FAIL err_pulse err=%b count=%0d want 1/1", wen_err, count); end
      tick();
      n_checks++; if (wen_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", wen_err); end
      st_valid = 1'b1; st_addr = 32'h58; st_wen = 4'b0000;
      tick();
      st_valid = 1'b0;
      n_checks++; if (wen_err !== 1'b0 || count !== 3'd1) begin n_fail++; $display("FAIL err_none err=%b count=%0d want 0/1", wen_err, count); end
      put(32'h5C, 32'h1234, 4'b0011);
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL err_half count got %0d want 2", count); end
      drain_hold = 1'b0;
      wait_empty("err");
   endtask

   task automatic test_reset_mid();
      int n_obs;
      drain_hold = 1'b1;
      put(32'h60, 32'h600, 4'b1111);
      put(32'h61, 32'h601, 4'b1111);
      put(32'h62, 32'h602, 4'b1111);
      drain_hold = 1'b0;
      #1;
      n_checks++; if (mem_wen !== 4'b1111 || mem_addr !== 32'h60) begin n_fail++; $display("FAIL rmid_drain wen=%b addr=%h want 1111/60", mem_wen, mem_addr); end
      tick();
      rst = 1'b1;
      #1;
      n_checks++; if (count !== 3'd0 || mem_wen !== 4'b0000 || empty !== 1'b1) begin n_fail++; $display("FAIL rmid_reset count=%0d wen=%b empty=%b want 0/0000/1", count, mem_wen, empty); end
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      n_obs = obs_q.size();
      tick();
      tick();
      rst = 1'b0;
      repeat (4) tick();
      n_checks++; if (obs_q.size() !== n_obs || empty !== 1'b1) begin n_fail++; $display("FAIL rmid_after writes=%0d want %0d empty=%b", obs_q.size(), n_obs, empty); end
   endtask

   task automatic test_write_order();
      wr_t e;
      wr_t o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL order_missing addr=%h data=%h wen=%b never written", e.a, e.d, e.w);
         end else begin
            o = obs_q.pop_front();
            if (o.a !== e.a || o.d !== e.d || o.w !== e.w) begin
               n_fail++; $display("FAIL order got %h/%h/%b want %h/%h/%b", o.a, o.d, o.w, e.a, e.d, e.w);
            end
         end
      end
      n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL order_extra %0d unexpected writes", obs_q.size()); end
   endtask

   initial begin
      rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_wen = '0;
      ld_en = 1'b0; ld_addr = '0; drain_hold = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_full_order();
      test_fwd_full();
      test_partial();
      test_wen_err();
      test_reset_mid();
      test_write_order();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
